// File: rtl/led_phy_pkg.sv
// Shared LED PHY definitions: word width, framing words and the
// scheduler state encoding. GAP state exists only with LED_SCHED_GAP_EN.
package led_phy_pkg;

   localparam int          LED_FRAME_W    = 32;
   localparam logic [31:0] LED_START_WORD = 32'h0000_0000;
   localparam logic [31:0] LED_END_WORD   = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_START_FRM,
      ST_LED_FRM,
      ST_END_FRM,
      ST_DONE
`ifdef LED_SCHED_GAP_EN
      , ST_GAP
`endif
   } led_sched_state_t;

endpackage

// File: rtl/led_frame_scheduler.sv
// Frames one LED refresh packet: start word, led_num pixel words, end word,
// then (with LED_SCHED_GAP_EN) a GAP_CYCLES idle latch gap.
// Ports: clk/rst_n; start/cfg_led_num request; busy/done/total_bits status;
// pix_* valid/ready from the pixel buffer; phy_* valid/ready to the serializer.
module led_frame_scheduler
   import led_phy_pkg::*;
#(
   parameter int                 FRAME_W    = LED_FRAME_W,
   parameter int                 NUM_W      = 5,
   parameter int                 GAP_CYCLES = 32,
   parameter logic [FRAME_W-1:0] START_WORD = LED_START_WORD,
   parameter logic [FRAME_W-1:0] END_WORD   = LED_END_WORD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [NUM_W-1:0]   cfg_led_num,
   output logic               busy,
   output logic               done,
   output logic [10:0]        total_bits,
   input  logic [FRAME_W-1:0] pix_data,
   input  logic               pix_valid,
   output logic               pix_ready,
   output logic [FRAME_W-1:0] phy_data,
   output logic               phy_valid,
   input  logic               phy_ready
);

   led_sched_state_t r_state;
   led_sched_state_t w_next;
   logic [NUM_W-1:0] r_led_num;
   logic [NUM_W-1:0] r_led_cnt;
   logic [10:0]      r_total_bits;
   logic             w_pix_xfer;
   logic             w_last_led;

`ifdef LED_SCHED_GAP_EN
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             w_gap_end;
   assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

   assign w_pix_xfer = (r_state == ST_LED_FRM) && pix_valid && phy_ready;
   // Only consulted in LED_FRM, where led_num is known non-zero.
   assign w_last_led = (r_led_cnt == (r_led_num - 1'b1));

   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign total_bits = r_total_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_led_num    <= '0;
         r_led_cnt    <= '0;
         r_total_bits <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE) begin
            r_led_cnt <= '0;
            if (start) r_led_num <= cfg_led_num;
         end
         if (r_state == ST_CALC)
            r_total_bits <= (11'(r_led_num) + 11'd2) << 5;
         if (w_pix_xfer)
            r_led_cnt <= r_led_cnt + 1'b1;
      end
   end

`ifdef LED_SCHED_GAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_gap_cnt <= '0;
      else if (r_state == ST_GAP)
         r_gap_cnt <= r_gap_cnt + 1'b1;
      else
         r_gap_cnt <= '0;
   end
`endif

   always_comb begin
      w_next    = r_state;
      phy_valid = 1'b0;
      phy_data  = '0;
      pix_ready = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_CALC;
         end
         ST_CALC: begin
            w_next = ST_START_FRM;
         end
         ST_START_FRM: begin
            phy_valid = 1'b1;
            phy_data  = START_WORD;
            if (phy_ready)
               w_next = (r_led_num != '0) ? ST_LED_FRM : ST_END_FRM;
         end
         ST_LED_FRM: begin
            phy_valid = pix_valid;
            phy_data  = pix_data;
            pix_ready = phy_ready;
            if (w_pix_xfer && w_last_led) w_next = ST_END_FRM;
         end
         ST_END_FRM: begin
            phy_valid = 1'b1;
            phy_data  = END_WORD;
`ifdef LED_SCHED_GAP_EN
            if (phy_ready) w_next = ST_GAP;
`else
            if (phy_ready) w_next = ST_DONE;
`endif
         end
`ifdef LED_SCHED_GAP_EN
         ST_GAP: begin
            if (w_gap_end) w_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler: expected PHY words are queued
// when a packet is requested and popped on every PHY transfer.
module tb_led_frame_scheduler;

   localparam int GAPX =
`ifdef LED_SCHED_GAP_EN
      32;
`else
      0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  cfg_led_num;
   logic        busy;
   logic        done;
   logic [10:0] total_bits;
   logic [31:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [31:0] phy_data;
   logic        phy_valid;
   logic        phy_ready;

   int vecs = 0;
   int errs = 0;
   logic [31:0] exp_q[$];

   led_frame_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_led_num (cfg_led_num),
      .busy        (busy),
      .done        (done),
      .total_bits  (total_bits),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .phy_data    (phy_data),
      .phy_valid   (phy_valid),
      .phy_ready   (phy_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_tbits"}, 32'(total_bits), 0);
      chk({tag, "_pvalid"}, 32'(phy_valid), 0);
      chk({tag, "_pdata"}, phy_data, 0);
      chk({tag, "_xready"}, 32'(pix_ready), 0);
   endtask

   // mode 0: no stalls, 1: phy_ready toggles, 2: pix_valid gap,
   // 3: start+cfg change mid-packet, 4: reset abort at LED word 2
   task automatic run_packet(input int n, input int mode, input int alt);
      logic [31:0] pix[$];
      logic [31:0] held;
      logic [31:0] w;
      int idx;
      bit seen_done;
      bit stalled;
      bit pr_seen;
      idx = 0;
      seen_done = 0;
      stalled = 0;
      pr_seen = 0;
      held = '0;
      pix.delete();
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         pix.push_back(w);
         exp_q.push_back(w);
      end
      exp_q.push_back(32'hFFFF_FFFF);
      cfg_led_num = 5'(n);
      for (int k = 0; k < 600 && !seen_done; k++) begin
         @(negedge clk);
         start = (k == 0) || (mode == 3 && k == 4);
         if (mode == 3 && k == 3) cfg_led_num = 5'(alt);
         phy_ready = (mode == 1) ? (k % 2 == 0) : 1'b1;
         pix_valid = !(mode == 2 && k >= 5 && k < 10);
         pix_data = (idx < n) ? pix[idx] : 32'hDEAD_BEEF;
         if (mode == 4 && idx == 2) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            chk_reset_outs("abort");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         #1;
         if (k == 1) chk("busy_calc", 32'(busy), 1);
         if (k == 2) begin
            chk("total_bits", 32'(total_bits), 32'((n + 2) * 32));
            chk("valid_t2", 32'(phy_valid), 1);
         end
         if (stalled && phy_valid) chk("stall_hold", phy_data, held);
         stalled = phy_valid && !phy_ready;
         held = phy_data;
         if (pix_ready) pr_seen = 1;
         if (phy_valid && phy_ready) begin
            if (exp_q.size() == 0) chk("extra_word", phy_data, 32'hxxxx_xxxx);
            else chk("phy_word", phy_data, exp_q.pop_front());
         end
         if (pix_valid && pix_ready) idx++;
         if (done) begin
            seen_done = 1;
            if (mode == 0 || mode == 3)
               chk("done_lat", 32'(k), 32'(n + 4 + GAPX));
            chk("words_left", 32'(exp_q.size()), 0);
         end
      end
      start = 1'b0;
      if (!seen_done) chk("timeout", 0, 1);
      if (n == 0) chk("pix_ready_n0", 32'(pr_seen), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      cfg_led_num = '0;
      pix_data = '0;
      pix_valid = 1'b0;
      phy_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      run_packet(3, 0, 0);
      run_packet(0, 0, 0);
      run_packet(31, 1, 0);
      run_packet(8, 2, 0);
      run_packet(5, 3, 2);
      run_packet(2, 0, 0);
      run_packet(4, 4, 0);
      run_packet(6, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Sequences one LED refresh packet on the LED PHY path: a start word, `led_num` pixel words and an end word, then an optional latch gap. On `start` it latches the LED count and computes the packet bit length. It then meters 32-bit words from the pixel source to the PHY serializer over valid/ready handshakes. It sits between the pixel buffer and the bit serializer and is the single owner of packet framing.

## Interface
- `FRAME_W`, 32: bits per word; the arithmetic below requires 32.
- `NUM_W`, 5: width of the LED count; at most 31 LEDs.
- `GAP_CYCLES`, 32: idle cycles after the end word (used only with the gap feature).
- `START_WORD`, 32'h0000_0000: start-of-packet word.
- `END_WORD`, 32'hFFFF_FFFF: end-of-packet word.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle packet request; sampled only in IDLE.
- `cfg_led_num`  in  NUM_W  LED count; sampled on the cycle `start` is accepted.
- `busy`  out  1  high from CALC through DONE inclusive.
- `done`  out  1  one-cycle pulse in DONE.
- `total_bits`  out  11  `(led_num+2)*32`; valid from the cycle after CALC until the next CALC.
- `pix_data`  in  FRAME_W  pixel word from the buffer.
- `pix_valid`  in  1  pixel word available.
- `pix_ready`  out  1  pixel word consumed this cycle.
- `phy_data`  out  FRAME_W  word to the serializer.
- `phy_valid`  out  1  `phy_data` valid.
- `phy_ready`  in  1  serializer accepts the word.

## Operation
- States: IDLE, CALC, START_FRM, LED_FRM, END_FRM, GAP, DONE.
- IDLE:
  - `start`=1 → CALC.
  - `led_num_q` ← `cfg_led_num`; `led_cnt` ← 0.
- CALC:
  - `total_bits` ← `({6'b0,led_num_q} + 2) << 5`, 11-bit result; maximum (31+2)*32 = 1056, so no overflow.
  - → START_FRM.
- START_FRM:
  - `phy_valid`=1, `phy_data`=START_WORD.
  - On `phy_ready`: → LED_FRM if `led_num_q`≠0, else → END_FRM.
- LED_FRM:
  - Combinational pass-through: `phy_valid`=`pix_valid`, `phy_data`=`pix_data`, `pix_ready`=`phy_ready`.
  - A word transfers when `pix_valid && phy_ready`; `led_cnt` then increments.
  - On the transfer with `led_cnt == led_num_q-1`: → END_FRM.
- END_FRM:
  - `phy_valid`=1, `phy_data`=END_WORD.
  - On `phy_ready`: → GAP (feature enabled) or → DONE.
- GAP:
  - `phy_valid`=0; `gap_cnt` counts 0..GAP_CYCLES-1.
  - → DONE on the cycle `gap_cnt`==GAP_CYCLES-1.
- DONE: `done`=1 → IDLE.
- Outside LED_FRM: `pix_ready`=0.
- Outside START_FRM/LED_FRM/END_FRM: `phy_valid`=0.
- `start` while `busy`=1 is ignored; there is no queueing.
- A `cfg_led_num` change mid-packet has no effect.
- Stalls: while `phy_ready`=0, `phy_data` and `phy_valid` are held stable. In LED_FRM they follow the source; the source must hold `pix_data` while `pix_valid && !pix_ready`.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `total_bits`=0, `phy_valid`=0, `phy_data`=0, `pix_ready`=0; all counters 0.
- Reset asserted mid-packet aborts immediately to these values, with no end word. The serializer must discard any partial packet.
- `start` accepted at cycle T:
  - CALC at T+1.
  - `total_bits` valid and `phy_valid`=1 at T+2.
- Zero-stall packet, `led_num`=N: `done` at T+N+4 (without gap) or T+N+4+GAP_CYCLES (with gap).
- `start` may be accepted in the IDLE cycle directly after DONE. Minimum packet-to-packet spacing is therefore N+5 cycles.

## Configuration
- `LED_SCHED_GAP_EN` defined:
  - GAP state and `gap_cnt` are compiled in.
  - Latch time is GAP_CYCLES cycles after the end word.
- `LED_SCHED_GAP_EN` undefined:
  - No GAP state and no `gap_cnt`; END_FRM goes straight to DONE.
  - The downstream serializer must provide latch time itself.

## Structure
- Shared package `led_phy_pkg`:
  - state enum `led_sched_state_t`.
  - `LED_FRAME_W`=32.
  - `LED_START_WORD`, `LED_END_WORD`.
- Single module, no sub-module. Length calculation is one shift-add in CALC, so a separate calculator instance adds latency without benefit.

## Test plan
- `led_num`=3, `phy_ready`=1, `pix_valid`=1, gap on, GAP_CYCLES=32 → `phy_data` sequence 0x00000000, P0, P1, P2, 0xFFFFFFFF; `total_bits`=160; `done` at T+39.
- `led_num`=0 → start word then end word only; `pix_ready` never asserts; `total_bits`=64.
- `led_num`=31, `phy_ready` toggling 1/0 every cycle → 33 words delivered in order, `phy_data` stable during stalls, `total_bits`=1056.
- `pix_valid` low for 5 cycles mid-LED_FRM → no word emitted and `led_cnt` frozen; resumes with the next pixel and no duplicates.
- `start` pulsed while `busy`, and `cfg_led_num` changed mid-packet → no effect on the current packet; the next `start` after DONE uses the new value.
- `rst_n` low during LED_FRM word 2 → next cycle all outputs are at reset values; a following `start` produces a complete packet.
